// File: rtl/ved_16x16.sv
// ved_16x16 -- registered 16x16 -> 32 unsigned multiplier built as a Vedic
// (Urdhva-Tiryagbhyam) hierarchy: 2x2 cells -> 4x4 -> 8x8 -> 16x16.
//
// Ports (top module ved_16x16):
//   clk     in   1   single clock, rising edge
//   rst     in   1   synchronous active-high reset, clears result
//   a       in  16   unsigned multiplicand
//   b       in  16   unsigned multiplier
//   result  out 32   a*b of the operands sampled at the previous rising edge
//
// The multiply tree is purely combinational; the only state is the output
// register, so latency is exactly one cycle and a new pair is taken every cycle.

// 2x2 cell: four bit products folded with two half adders.
module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic a0b0, a1b0, a0b1, a1b1;
    logic c1;

    assign a0b0 = a[0] & b[0];
    assign a1b0 = a[1] & b[0];
    assign a0b1 = a[0] & b[1];
    assign a1b1 = a[1] & b[1];

    assign p[0] = a0b0;
    assign p[1] = a1b0 ^ a0b1;
    assign c1   = a1b0 & a0b1;
    assign p[2] = a1b1 ^ c1;
    assign p[3] = a1b1 & c1;
endmodule

// Recombines the four half-width partial products of an NxN level:
//   P = LL + ((HL + LH) << N/2) + (HH << N)
// The low N/2 bits of LL cannot receive any carry, so they go straight to
// the product; everything else is summed in a 3N/2-bit adder, which is
// exactly the width left above them, so no carry can be lost.
module vedic_add #(
    parameter int N = 4
) (
    input  logic [N-1:0]   ll,
    input  logic [N-1:0]   hl,
    input  logic [N-1:0]   lh,
    input  logic [N-1:0]   hh,
    output logic [2*N-1:0] p
);
    localparam int H = N / 2;

    logic [N:0]     mid;    // HL + LH, one extra bit for the carry
    logic [3*H-1:0] upper;  // product bits [2N-1:H]

    assign mid   = {1'b0, hl} + {1'b0, lh};
    // HH sits at bit N of the product, i.e. bit H of 'upper', so it can be
    // concatenated above the upper half of LL instead of needing its own adder.
    assign upper = {hh, ll[N-1:H]} + {{(H-1){1'b0}}, mid};
    assign p     = {upper, ll[H-1:0]};
endmodule

module vedic_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] ll, hl, lh, hh;

    vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(ll));
    vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(hl));
    vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(lh));
    vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(hh));

    vedic_add #(.N(4)) u_add (.ll(ll), .hl(hl), .lh(lh), .hh(hh), .p(p));
endmodule

module vedic_8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [7:0] ll, hl, lh, hh;

    vedic_4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(ll));
    vedic_4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(hl));
    vedic_4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(lh));
    vedic_4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(hh));

    vedic_add #(.N(8)) u_add (.ll(ll), .hl(hl), .lh(lh), .hh(hh), .p(p));
endmodule

module ved_16x16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] result
);
    logic [15:0] ll, hl, lh, hh;
    logic [31:0] product;

    vedic_8x8 u_ll (.a(a[7:0]),  .b(b[7:0]),  .p(ll));
    vedic_8x8 u_hl (.a(a[15:8]), .b(b[7:0]),  .p(hl));
    vedic_8x8 u_lh (.a(a[7:0]),  .b(b[15:8]), .p(lh));
    vedic_8x8 u_hh (.a(a[15:8]), .b(b[15:8]), .p(hh));

    vedic_add #(.N(16)) u_add (.ll(ll), .hl(hl), .lh(lh), .hh(hh), .p(product));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, matching the hardware regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= 32'h0000_0000;
        end else begin
            result <= product;
        end
    end
endmodule

// File: tb/tb_ved_16x16.sv
// Self-checking bench for ved_16x16: reset behaviour, directed products with
// hand-computed values, operand changes between edges, and a long random run
// with one mid-run reset pulse.
module tb_ved_16x16;
    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    ved_16x16 dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply operands, take one rising edge, then settle 1 time unit past it.
    task automatic step(input logic [15:0] ta, input logic [15:0] tb, input logic tr);
        a   = ta;
        b   = tb;
        rst = tr;
        @(posedge clk);
        #1;
    endtask

    // Directed vectors: operand pair and hand-computed product.
    localparam int ND = 15;
    logic [15:0] da [ND] = '{16'd5, 16'd6, 16'd9, 16'd15, 16'd30, 16'd25,
                             16'd255, 16'd255, 16'd255,
                             16'd500, 16'd1000, 16'hFFFF,
                             16'hFFFF, 16'h8000, 16'd1};
    logic [15:0] db [ND] = '{16'd6, 16'd7, 16'd7, 16'd15, 16'd30, 16'd25,
                             16'd250, 16'd254, 16'd255,
                             16'd500, 16'd1000, 16'hFFFF,
                             16'd0, 16'd2, 16'hABCD};
    logic [31:0] dp [ND] = '{32'd30, 32'd42, 32'd63, 32'd225, 32'd900, 32'd625,
                             32'd63750, 32'd64770, 32'h0000FE01,
                             32'd250000, 32'h000F4240, 32'hFFFE0001,
                             32'd0, 32'h00010000, 32'h0000ABCD};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ra, rb;
        logic [31:0] exp;
        logic        r;

        a   = 16'h0;
        b   = 16'h0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset dominates operands, release gives the product with no recovery cycle.
        step(16'h1234, 16'h5678, 1'b1);
        check("reset_clears", result, 32'h0000_0000);
        step(16'h1234, 16'h5678, 1'b0);
        check("reset_release", result, 32'h0626_0060);

        // Directed vectors, one pair per cycle.
        for (int i = 0; i < ND; i++) begin
            step(da[i], db[i], 1'b0);
            check($sformatf("dir%0d_%0dx%0d", i, da[i], db[i]), result, dp[i]);
        end

        // Zero on the a side.
        step(16'h0000, 16'hFFFF, 1'b0);
        check("zero_a", result, 32'h0);

        // Operands changed between edges do not reach result until the next edge.
        step(16'd300, 16'd300, 1'b0);
        check("hold_pre", result, 32'd90000);
        a = 16'hFFFF;
        b = 16'hFFFF;
        #2;
        check("hold_between_edges", result, 32'd90000);
        @(posedge clk);
        #1;
        check("hold_post", result, 32'hFFFE0001);

        // Random back-to-back pairs with a single reset pulse mid-run.
        for (int i = 0; i < 10000; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            r   = (i == 5000);
            exp = r ? 32'h0 : ({16'h0, ra} * {16'h0, rb});
            step(ra, rb, r);
            check(r ? "rand_reset" : "rand", result, exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ved_16x16.md
VED_16X16 -- requirements
Module: ved_16x16

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 16x16->32.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port a  input  16  SHALL be the unsigned multiplicand.
REQ-005 Port b  input  16  SHALL be the unsigned multiplier.
REQ-006 Port result  output  32  SHALL be the registered unsigned product of a and b.
REQ-007 Port order SHALL be clk, rst, a, b, result.

Function
REQ-008 The block SHALL compute result = a * b, unsigned, full 32-bit width, with no truncation, saturation or overflow flag.
REQ-009 The product datapath SHALL be purely combinational from a/b to one output register; result SHALL update on every rising clk edge when rst is low.
REQ-010 Latency SHALL be exactly 1 cycle: a/b sampled at edge N -> product visible on result after edge N; no handshake, no valid signal, a new operand pair is accepted every cycle.
REQ-011 The datapath SHALL be a Vedic (Urdhva-Tiryagbhyam) hierarchy, without using a behavioural multiply operator:
- 2x2 cell: bit products and half adders -> 4-bit product;
- 4x4 from four 2x2, 8x8 from four 4x4, 16x16 from four 8x8.
REQ-012 Each NxN level SHALL split operands into high (H) and low (L) halves and form P = LL + ((HL + LH) << N/2) + (HH << N), with adder widths wide enough that no carry is lost.
REQ-013 The bits of LL below position N/2 SHALL pass straight to the low part of the level's product; only the upper bits SHALL enter the adders.
REQ-014 Boundary: a=0 or b=0 SHALL give result=0; a=b=0xFFFF SHALL give 0xFFFE0001 (maximum product, all carries propagate).
REQ-015 Operand changes between edges SHALL have no effect on result until the next rising edge.

Reset
REQ-016 While rst is high at a rising edge, result SHALL be loaded with 0x00000000, regardless of a and b.
REQ-017 After the first rising edge with rst low, result SHALL hold the product of the operands sampled at that edge; no additional recovery cycles.
REQ-018 Reset asserted mid-stream SHALL discard the pending product; rst has no asynchronous effect.

Verification
REQ-019 Reset: rst=1, a=0x1234, b=0x5678, one edge -> result=0; release rst, same operands, one edge -> result=0x06260060.
REQ-020 Small values, one pair per cycle, each result 1 cycle later:
- 5x6 -> 30
- 6x7 -> 42
- 9x7 -> 63
- 15x15 -> 225
- 30x30 -> 900
- 25x25 -> 625
REQ-021 Byte boundary:
- 255x250 -> 63750
- 255x254 -> 64770
- 255x255 -> 65025 (0x0000FE01)
REQ-022 Wider operands:
- 500x500 -> 250000
- 1000x1000 -> 1000000 (0x000F4240)
- 65535x65535 -> 4294836225 (0xFFFE0001)
REQ-023 Zero and identity:
- 0xFFFFx0 -> 0
- 0x8000x2 -> 0x00010000
- 1x0xABCD -> 0x0000ABCD
REQ-024 Random: at least 10000 random a/b pairs back-to-back -> every result equals the reference 32-bit product delayed 1 cycle; rst pulsed once mid-run -> result=0 on that cycle only.
